path_tracer: RTL
================

Name: path_tracer

Overview:
- Consumer end of the shortest-path planner's predecessor table.
- Given a source and a goal node, it walks the predecessor table backwards from goal to source and stacks each node in an internal LIFO.
- It then streams the path in forward order (source first, goal last) over a valid/ready interface, for the motion/route controller.
- Unreachable goals, malformed tables (cycles, over-long paths) and bad arguments are reported as errors instead of a stream.

Parameters:
- N_NODES, 64, number of graph nodes; valid node IDs are 0..N_NODES-1.
- NODE_W, 8, width of a node ID and of a table entry.
- NONE_ID, 8'hFF, table value meaning "no predecessor".
- MAX_LEN, 64, LIFO depth; maximum path length in nodes, including source and goal.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- src  in  NODE_W  source node; captured with start.
- goal  in  NODE_W  goal node; captured with start.
- pred_rd  out  1  table read strobe.
- pred_addr  out  NODE_W  table read address.
- pred_data  in  NODE_W  table read data; valid exactly 1 cycle after pred_rd.
- out_valid  out  1  path node available.
- out_ready  in  1  downstream accepts the node.
- out_node  out  NODE_W  path node ID.
- out_last  out  1  marks the goal node (final beat).
- busy  out  1  high from accepted start until return to IDLE.
- done  out  1  1-cycle pulse after the last beat handshakes.
- err  out  1  1-cycle pulse on an aborted trace.
- err_code  out  2  1 = unreachable, 2 = over-length, 3 = bad argument; holds until the next start.
- path_len  out  7  nodes in the last successful path; holds until the next success.

Behaviour:
- Reset: asynchronous on the falling edge of rst, released synchronously. All outputs go to 0 and the FSM goes to IDLE. The LIFO pointer clears; LIFO contents are don't-care.
- Reset mid-operation aborts immediately. No done or err is produced for the aborted request.
- States: IDLE, REQ, CHECK, EMIT, FIN, FAIL.
- IDLE:
  - On start: if src >= N_NODES or goal >= N_NODES, go to FAIL with code 3.
  - Otherwise push goal (sp=1) and set cur=goal. If goal==src, go to EMIT; else go to REQ.
  - busy rises in the cycle after start.
- REQ: assert pred_rd=1 with pred_addr=cur for one cycle; go to CHECK.
- CHECK: pred_data is valid this cycle. Evaluate in priority order:
  1. pred_data==NONE_ID or pred_data>=N_NODES -> FAIL, code 1.
  2. sp==MAX_LEN -> FAIL, code 2. This also catches cyclic tables.
  3. Otherwise push pred_data and sp++. If pred_data==src go to EMIT; else set cur=pred_data and go to REQ.
- Cost: 2 cycles per hop. An H-hop path has its first out_valid 2H+1 cycles after start.
- EMIT:
  - out_valid=1, out_node=lifo[sp-1], out_last=(sp==1).
  - out_node and out_last stay stable while out_valid && !out_ready.
  - On handshake, pop (sp--). On the handshake of the out_last beat, go to FIN.
  - out_ready is ignored outside EMIT.
- FIN: done=1 for one cycle, path_len = pushed count; go to IDLE with busy=0.
- FAIL: err=1 for one cycle, err_code updated, no output beats; go to IDLE with busy=0.
- start while busy is ignored; it is not queued.
- LIFO is never pushed beyond MAX_LEN and never popped below 0.
- pred_rd is only ever asserted in REQ.

Test Plan:
- Chain: table prev[5]=3, prev[3]=1; src=1, goal=5.
  - Reads at addresses 5 then 3.
  - Stream 1,3,5 with out_last on 5.
  - done pulse; path_len=3; first out_valid 5 cycles after start.
- Backpressure: same chain, out_ready low for 4 cycles on each beat.
  - out_node stable while stalled; no beat lost or duplicated; order still 1,3,5.
- Trivial and bad-argument requests:
  - src=goal=7 -> no pred_rd; single beat 7 with out_last; path_len=1.
  - src=70 -> err pulse, err_code=3, no beats.
- Unreachable: prev[9]=NONE_ID; src=0, goal=9 -> one read at 9, err_code=1, err pulse, busy drops, no beats.
- Cycle: prev[2]=4, prev[4]=2; src=0, goal=2 -> err_code=2 once 64 nodes are stacked, no beats.
- Reset and start-while-busy:
  - rst low mid-EMIT -> all outputs 0 immediately; next request traces correctly.
  - A second start while busy is ignored.

Source files
------------

// File: rtl/path_tracer.sv
// path_tracer - walks a predecessor table from goal back to source, stacks the nodes
// in a LIFO and streams the path source-first over a valid/ready port.
module path_tracer #(
  parameter int              N_NODES = 64,
  parameter int              NODE_W  = 8,
  parameter logic [NODE_W-1:0] NONE_ID = 8'hFF,
  parameter int              MAX_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NODE_W-1:0] src,
  input  logic [NODE_W-1:0] goal,
  output logic              pred_rd,
  output logic [NODE_W-1:0] pred_addr,
  input  logic [NODE_W-1:0] pred_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NODE_W-1:0] out_node,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [6:0]        path_len
);

  localparam int SP_W = $clog2(MAX_LEN + 1);
  localparam int AW   = $clog2(MAX_LEN);
  localparam logic [NODE_W-1:0] N_ID   = NODE_W'(N_NODES);
  localparam logic [SP_W-1:0]   MAX_SP = SP_W'(MAX_LEN);
  localparam logic [SP_W-1:0]   SP_ONE = SP_W'(1);

  typedef enum logic [2:0] {IDLE, REQ, CHECK, EMIT, FIN, FAIL} state_t;

  state_t            state_q, state_d;
  logic [NODE_W-1:0] src_q, src_d;
  logic [NODE_W-1:0] cur_q, cur_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [SP_W-1:0]   len_q, len_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [6:0]        path_len_q, path_len_d;

  logic [NODE_W-1:0] lifo_q [MAX_LEN];
  logic              push;
  logic [AW-1:0]     push_addr;
  logic [NODE_W-1:0] push_data;
  logic [AW-1:0]     rd_idx;

  // sp == MAX_LEN wraps the low bits to 0, so minus one still lands on the top entry.
  assign rd_idx = sp_q[AW-1:0] - AW'(1);

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    cur_d      = cur_q;
    sp_d       = sp_q;
    len_d      = len_q;
    err_code_d = err_code_q;
    path_len_d = path_len_q;
    push       = 1'b0;
    push_addr  = '0;
    push_data  = '0;
    pred_rd    = 1'b0;
    pred_addr  = '0;
    out_valid  = 1'b0;
    out_node   = '0;
    out_last   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          if (src >= N_ID || goal >= N_ID) begin
            err_code_d = 2'd3;
            state_d    = FAIL;
          end else begin
            err_code_d = 2'd0;
            src_d      = src;
            cur_d      = goal;
            push       = 1'b1;
            push_addr  = '0;
            push_data  = goal;
            sp_d       = SP_ONE;
            len_d      = SP_ONE;
            state_d    = (goal == src) ? EMIT : REQ;
          end
        end
      end
      REQ: begin
        pred_rd   = 1'b1;
        pred_addr = cur_q;
        state_d   = CHECK;
      end
      CHECK: begin
        if (pred_data == NONE_ID || pred_data >= N_ID) begin
          err_code_d = 2'd1;
          sp_d       = '0;
          state_d    = FAIL;
        end else if (sp_q == MAX_SP) begin
          err_code_d = 2'd2;
          sp_d       = '0;
          state_d    = FAIL;
        end else begin
          push      = 1'b1;
          push_addr = sp_q[AW-1:0];
          push_data = pred_data;
          sp_d      = sp_q + SP_ONE;
          if (pred_data == src_q) begin
            len_d   = sp_q + SP_ONE;
            state_d = EMIT;
          end else begin
            cur_d   = pred_data;
            state_d = REQ;
          end
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_node  = lifo_q[rd_idx];
        out_last  = (sp_q == SP_ONE);
        if (out_ready) begin
          sp_d = sp_q - SP_ONE;
          if (sp_q == SP_ONE) begin
            path_len_d = 7'(len_q);
            state_d    = FIN;
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      FAIL: begin
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_code = err_code_q;
  assign path_len = path_len_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      src_q      <= '0;
      cur_q      <= '0;
      sp_q       <= '0;
      len_q      <= '0;
      err_code_q <= '0;
      path_len_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      cur_q      <= cur_d;
      sp_q       <= sp_d;
      len_q      <= len_d;
      err_code_q <= err_code_d;
      path_len_q <= path_len_d;
    end
  end

  // Stack storage needs no reset; only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      lifo_q[push_addr] <= push_data;
    end
  end

endmodule
